// File: rtl/wb_pkg.sv
// Writeback stage shared types and defaults.
// Default widths are also used by the register file.
package wb_pkg;

    localparam int WB_DW   = 16;
    localparam int WB_NSRC = 4;
    localparam int WB_AW   = 3;

    function automatic int sel_w(input int nsrc);
        return (nsrc > 2) ? $clog2(nsrc) : 1;
    endfunction

    typedef struct packed {
        logic [WB_DW-1:0] data;
        logic [WB_AW-1:0] rd;
        logic             we;
    } wb_beat_t;

endpackage

// File: rtl/wb_mux_stage_if.sv
// Writeback select stage bus: sources in, registered beat out.
// master drives sources/handshake, slave is the stage.
interface wb_mux_stage_if
    import wb_pkg::*;
#(
    parameter int DW   = WB_DW,
    parameter int NSRC = WB_NSRC,
    parameter int AW   = WB_AW
);
    localparam int SEL_W = sel_w(NSRC);

    logic [NSRC*DW-1:0] src_data;
    logic [SEL_W-1:0]   src_sel;
    logic [AW-1:0]      in_rd;
    logic               in_we;
    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic [DW-1:0]      out_data;
    logic [AW-1:0]      out_rd;
    logic               out_we;
    logic               out_valid;
    logic               out_ready;
    logic               sel_err;

    modport master (
        output src_data, src_sel, in_rd, in_we, in_valid,
        output flush, out_ready,
        input  in_ready, out_data, out_rd, out_we, out_valid,
        input  sel_err
    );

    modport slave (
        input  src_data, src_sel, in_rd, in_we, in_valid,
        input  flush, out_ready,
        output in_ready, out_data, out_rd, out_we, out_valid,
        output sel_err
    );

endinterface

// File: rtl/wb_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush.
// in_ready is a pure flop output: no path from out_ready.
module wb_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] skid_q;
    logic         skid_v;
    logic         acc;

    assign in_ready = !skid_v;
    assign acc      = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_v    <= 1'b0;
            skid_q    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_v    <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // Skid entry is older than anything upstream, drain it first
            if (skid_v) begin
                out_data  <= skid_q;
                out_valid <= 1'b1;
                skid_v    <= 1'b0;
            end else if (acc) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (acc) begin
            skid_q <= in_data;
            skid_v <= 1'b1;
        end
    end

endmodule

// File: rtl/wb_mux_stage.sv
// Writeback select stage: source mux, we qualification, output register.
// Define WB_SKID_EN to replace the output register with a skid buffer.
module wb_mux_stage
    import wb_pkg::*;
#(
    parameter int DW           = WB_DW,
    parameter int NSRC         = WB_NSRC,
    parameter int AW           = WB_AW,
    parameter int R0_HARDWIRED = 1
) (
    input  logic           clk,
    input  logic           rst,
    wb_mux_stage_if.slave  bus
);

    localparam int SEL_W = sel_w(NSRC);
    localparam int BW    = DW + AW + 1;
    localparam logic [SEL_W:0] NSRC_W = (SEL_W+1)'(NSRC);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] rd;
        logic          we;
    } beat_t;

    logic [DW-1:0] srcs [2**SEL_W];
    logic          sel_ok;
    logic          r0_hit;
    logic          accept;
    beat_t         nxt;
    beat_t         cur;

    // Pad to a power of two so every select code indexes a real entry
    for (genvar k = 0; k < 2**SEL_W; k++) begin : g_src
        if (k < NSRC) begin : g_v
            assign srcs[k] = bus.src_data[k*DW +: DW];
        end else begin : g_z
            assign srcs[k] = '0;
        end
    end

    assign sel_ok   = {1'b0, bus.src_sel} < NSRC_W;
    assign r0_hit   = (R0_HARDWIRED != 0) && (bus.in_rd == '0);
    assign nxt.data = sel_ok ? srcs[bus.src_sel] : '0;
    assign nxt.rd   = bus.in_rd;
    assign nxt.we   = bus.in_we & !r0_hit & sel_ok;
    assign accept   = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sel_err <= 1'b0;
        end else if (accept && !sel_ok) begin
            bus.sel_err <= 1'b1;
        end
    end

`ifdef WB_SKID_EN
    logic skid_rdy;
    logic [BW-1:0] skid_out;

    wb_skid_buf #(
        .W(BW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_data   (nxt),
        .in_valid  (bus.in_valid),
        .in_ready  (skid_rdy),
        .out_data  (skid_out),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready)
    );

    assign cur          = skid_out;
    assign bus.in_ready = skid_rdy & !bus.flush;
`else
    logic  vld_q;
    beat_t beat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            beat_q <= '0;
        end else if (bus.flush) begin
            vld_q <= 1'b0;
        end else if (accept) begin
            vld_q  <= 1'b1;
            beat_q <= nxt;
        end else if (bus.out_ready) begin
            vld_q <= 1'b0;
        end
    end

    assign cur           = beat_q;
    assign bus.out_valid = vld_q;
    assign bus.in_ready  = (!vld_q | bus.out_ready) & !bus.flush;
`endif

    assign bus.out_data = cur.data;
    assign bus.out_rd   = cur.rd;
    assign bus.out_we   = cur.we;

endmodule
